// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx_in, assembles LSB-first frames and
// queues good bytes in a show-ahead FIFO, pulsing ack for each accepted byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int N            = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_in,
  input  logic         data_read,
  input  logic         err_clear,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         ack,
  output logic         uart_busy,
  output logic         frame_error,
  output logic         overrun,
  output logic [2:0]   state_out
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [N-1:0]        shift_q, shift_d;
  logic [N-1:0]        mem_q [FIFO_DEPTH];
  logic [N-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ack_q, ack_d;
  logic                frame_error_q, frame_error_d;
  logic                overrun_q, overrun_d;

  logic rx_s;
  logic push;
  logic pop;
  logic can_accept;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d        = {sync_q[0], rx_in};
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    mem_d         = mem_q;
    push          = 1'b0;
    pop           = data_read && (count_q != '0);
    // A pop in the same cycle frees a slot even when the FIFO is full.
    can_accept    = (count_q < DEPTH_C) || pop;
    frame_error_d = err_clear ? 1'b0 : frame_error_q;
    overrun_d     = err_clear ? 1'b0 : overrun_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[N-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == FULL_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (can_accept) begin
              push = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ack_d    = push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ack_q         <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ack_q         <= ack_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_valid  = (count_q != '0);
  assign data_out    = data_valid ? mem_q[rd_ptr_q] : '0;
  assign ack         = ack_q;
  assign uart_busy   = (state_q != IDLE);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives 8N1 frames on rx_in
// and checks FIFO contents, ack timing, flags and FSM state.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic       data_read;
  logic       err_clear;
  logic [7:0] data_out;
  logic       data_valid;
  logic       ack;
  logic       uart_busy;
  logic       frame_error;
  logic       overrun;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_count = 0;
  int ack_base;
  int first_ack;

  uart_rx #(.CLKS_PER_BIT(16), .N(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .data_read  (data_read),
    .err_clear  (err_clear),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ack        (ack),
    .uart_busy  (uart_busy),
    .frame_error(frame_error),
    .overrun    (overrun),
    .state_out  (state_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every ack pulse, sampled half a cycle away from the active edge
  always @(negedge clk) begin
    if (ack === 1'b1) ack_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] b, input logic stop_bit, input int j);
    int idx;
    idx = j / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return stop_bit;
  endfunction

  // Drive one 160-cycle frame; first_ack gets the cycle (from the rx_in fall)
  // in which ack is first seen, or -1 if none.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic read_at_stop);
    first_ack = -1;
    for (int j = 0; j < 160; j++) begin
      rx_in     = frameBit(b, stop_bit, j);
      data_read = read_at_stop && (j == 154);
      tick();
      if (ack === 1'b1 && first_ack < 0) first_ack = j + 1;
    end
    data_read = 1'b0;
    rx_in     = 1'b1;
  endtask

  task automatic readByte(input string tag, input logic [7:0] exp);
    checkOutput({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
    checkOutput({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rx_in     = 1'b1;
    data_read = 1'b0;
    err_clear = 1'b0;
    idle(3);
    reset = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, data_out}, 32'd0);
    checkOutput("rst_ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_busy", {31'd0, uart_busy}, 32'd0);
    checkOutput("rst_ferr", {31'd0, frame_error}, 32'd0);
    checkOutput("rst_ovr", {31'd0, overrun}, 32'd0);
    checkOutput("rst_state", {29'd0, state_out}, 32'd0);

    $display("[TB] single frame 0xA5");
    ack_base = ack_count;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("a5_ack_cycle", first_ack, 32'd155);
    checkOutput("a5_ack_count", ack_count - ack_base, 32'd1);
    checkOutput("a5_ferr", {31'd0, frame_error}, 32'd0);
    readByte("a5", 8'hA5);
    checkOutput("a5_empty", {31'd0, data_valid}, 32'd0);

    $display("[TB] glitch");
    ack_base = ack_count;
    rx_in = 1'b0;
    idle(4);
    checkOutput("glitch_state_start", {29'd0, state_out}, 32'd1);
    checkOutput("glitch_busy", {31'd0, uart_busy}, 32'd1);
    rx_in = 1'b1;
    idle(20);
    checkOutput("glitch_state_idle", {29'd0, state_out}, 32'd0);
    checkOutput("glitch_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("glitch_ferr", {31'd0, frame_error}, 32'd0);
    checkOutput("glitch_acks", ack_count - ack_base, 32'd0);

    $display("[TB] framing error 0x3C then 0x81");
    ack_base = ack_count;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("ferr_state_wait", {29'd0, state_out}, 32'd4);
    checkOutput("ferr_flag", {31'd0, frame_error}, 32'd1);
    checkOutput("ferr_no_ack", ack_count - ack_base, 32'd0);
    idle(4);
    checkOutput("ferr_state_idle", {29'd0, state_out}, 32'd0);
    applyStimulus(8'h81, 1'b1, 1'b0);
    checkOutput("x81_ack_cycle", first_ack, 32'd155);
    checkOutput("ferr_sticky", {31'd0, frame_error}, 32'd1);
    readByte("x81", 8'h81);
    checkOutput("x81_empty", {31'd0, data_valid}, 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("ferr_cleared", {31'd0, frame_error}, 32'd0);

    $display("[TB] overrun with five frames");
    ack_base = ack_count;
    for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b1, 1'b0);
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_acks", ack_count - ack_base, 32'd4);
    for (int k = 1; k <= 4; k++) readByte("ovr_read", 8'(k));
    checkOutput("ovr_empty", {31'd0, data_valid}, 32'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("ovr_cleared", {31'd0, overrun}, 32'd0);

    $display("[TB] full FIFO with pop at stop sample");
    ack_base = ack_count;
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b1, 1'b0);
    applyStimulus(8'h05, 1'b1, 1'b1);
    checkOutput("pop_ack_cycle", first_ack, 32'd155);
    checkOutput("pop_no_ovr", {31'd0, overrun}, 32'd0);
    checkOutput("pop_acks", ack_count - ack_base, 32'd5);
    for (int k = 2; k <= 5; k++) readByte("pop_read", 8'(k));
    checkOutput("pop_empty", {31'd0, data_valid}, 32'd0);

    $display("[TB] reset during DATA bit 3 of 0x55");
    ack_base = ack_count;
    for (int j = 0; j < 70; j++) begin
      rx_in = frameBit(8'h55, 1'b1, j);
      tick();
    end
    checkOutput("rstmid_state_data", {29'd0, state_out}, 32'd2);
    reset = 1'b1;
    rx_in = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstmid_state_idle", {29'd0, state_out}, 32'd0);
    idle(20);
    checkOutput("rstmid_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rstmid_acks", ack_count - ack_base, 32'd0);
    applyStimulus(8'hF0, 1'b1, 1'b0);
    checkOutput("f0_ack_cycle", first_ack, 32'd155);
    checkOutput("f0_acks", ack_count - ack_base, 32'd1);
    checkOutput("f0_ferr", {31'd0, frame_error}, 32'd0);
    readByte("f0", 8'hF0);
    checkOutput("f0_empty", {31'd0, data_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver for the external communication path; the receive-direction counterpart of the uart_tx transmitter.
- Samples the external serial line and assembles 8N1 frames, LSB first.
- Buffers completed bytes in a small show-ahead FIFO for the bus-side adapter.
- Pulses ack to the external transmitter for every byte it accepts.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; even, >= 4
N, 8, data bits per frame
FIFO_DEPTH, 4, receive buffer entries; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
rx_in  input  1  external serial line; idles high
data_read  input  1  consumer pops the FIFO head this cycle
err_clear  input  1  clears frame_error and overrun
data_out  output  N  FIFO head byte; valid when data_valid=1
data_valid  output  1  FIFO not empty
ack  output  1  one-cycle pulse when a received byte is pushed
uart_busy  output  1  receiver not in IDLE
frame_error  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a good byte was dropped because the FIFO was full
state_out  output  3  current FSM state, for debug

Behaviour:
- Reset state: all outputs 0; data_out 0; FSM in IDLE; FIFO empty; both synchronizer flops = 1; all counters 0.
- rx_in passes through a 2-flop synchronizer, giving rx_s. All following timing is relative to rx_s.
- FSM encoding: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4. Codes 5-7 go to IDLE.
- IDLE: when rx_s=0 (cycle t0), clear the baud counter and go to START.
- START: at t0+CLKS_PER_BIT/2, sample rx_s.
  - rx_s=1: false start, return to IDLE; no flags, no ack.
  - rx_s=0: go to DATA with the bit counter cleared.
- DATA: bit i (i=0..N-1) is sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shifted in LSB first. After bit N-1, go to STOP.
- STOP: sample at t0+CLKS_PER_BIT/2+(N+1)*CLKS_PER_BIT.
  - rx_s=1 and the FIFO can accept: push the byte, go to IDLE.
  - rx_s=1 and the FIFO cannot accept: set overrun, drop the byte, no ack, go to IDLE.
  - rx_s=0: set frame_error, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. A line held low never produces a new frame.
- A new start bit may be detected the cycle after returning to IDLE; back-to-back frames are supported.
- ack is registered. It is high exactly in the cycle after a push, which is the same cycle data_valid first reflects that push. It never asserts for a dropped or errored frame.
- uart_busy = (state != IDLE).
- FIFO behaviour:
  - Show-ahead: data_out always equals the head entry; data_out is 0 when the FIFO is empty.
  - A pop occurs when data_read=1 and data_valid=1. data_read while empty is ignored.
  - Capacity check for a push: "can accept" means count < FIFO_DEPTH, or a pop occurs in the same cycle. Push and pop in the same cycle on a full FIFO leaves count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count width is clog2(FIFO_DEPTH)+1.
  - Byte order is strictly preserved.
- Flags:
  - frame_error and overrun are sticky until err_clear or reset.
  - If err_clear coincides with a new set event, the set wins.
- Reset mid-frame: at the next edge the FSM returns to IDLE, the partial byte is lost, the FIFO empties and no ack is issued.

Test Plan:
- Single frame, CLKS_PER_BIT=16, byte 0xA5 -> data_out=0xA5; data_valid and a 1-cycle ack rise together at (t0 of rx_in fall)+2+8+9*16+1 cycles; frame_error=0.
- Glitch: rx_in low for 4 cycles, then high -> state returns to IDLE; no ack, no data_valid, no flags.
- Frame 0x3C with stop bit driven 0, then line high, then a good 0x81 -> frame_error=1 and 0x3C never appears; 0x81 is received; err_clear pulse -> frame_error=0.
- Five frames 0x01..0x05 with no reads -> first four buffered in order, overrun=1, only 4 acks; reads return 0x01..0x04, then data_valid=0.
- FIFO full (0x01..0x04) with data_read asserted in the stop-sample cycle of 0x05 -> no overrun; reads return 0x02..0x05.
- Reset asserted during DATA bit 3 of 0x55, then frame 0xF0 -> no output for 0x55; 0xF0 received cleanly with an ack.
